// File: rtl/vga_frame_grabber.sv
// vga_frame_grabber: Avalon-MM slave that snoops the VGA pixel stream and
// buffers a windowed, optionally decimated region of one frame (or of every
// frame, in continuous mode) into a pixel FIFO for the host to drain.
module vga_frame_grabber #(
  parameter int PIXEL_W    = 8,
  parameter int FIFO_DEPTH = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chipselect,
  input  logic               read,
  input  logic               write,
  input  logic [7:0]         address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  input  logic [PIXEL_W-1:0] VGA_R,
  input  logic [PIXEL_W-1:0] VGA_G,
  input  logic [PIXEL_W-1:0] VGA_B,
  input  logic               HSYNC,
  input  logic               VSYNC,
  input  logic               PIX_EN,
  output logic               irq
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DW  = 3 * PIXEL_W;
  localparam int PAD = 32 - DW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;

  state_t state_q, state_d;

  // bus decode
  logic wr_ctrl, wr_stat, arm, abort, pop;
  assign wr_ctrl = chipselect & write & (address == 8'd0);
  assign wr_stat = chipselect & write & (address == 8'd1);
  assign arm     = wr_ctrl & writedata[0];
  assign abort   = wr_ctrl & writedata[3];

  // control / config registers
  logic        irq_en, cont;
  logic [31:0] win_x, win_y;
  logic [1:0]  decim;
  logic        done, overflow;
  logic [31:0] frame_cnt;

  // sync pipeline: one capture stage plus a previous copy for edge detect
  logic hs_r, hs_p, vs_r, vs_p, hs_edge, vs_edge;
  logic [15:0] x, y;

  // FIFO
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic          fifo_empty, fifo_full;
  logic          qual, push_req, push, drop, set_done, busy;
  logic [15:0]   dmask, x_off, y_off;

  assign level      = wr_ptr - rd_ptr;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
  assign pop        = chipselect & read & (address == 8'd5) & ~fifo_empty;
  assign busy       = (state_q == S_WAIT_VS) || (state_q == S_CAPTURE);
  assign irq        = irq_en & done;

  // register syncs; idle-high reset value so reset release never looks like an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_r <= 1'b1; hs_p <= 1'b1; vs_r <= 1'b1; vs_p <= 1'b1;
    end else begin
      hs_r <= HSYNC; hs_p <= hs_r; vs_r <= VSYNC; vs_p <= vs_r;
    end
  end

  assign hs_edge = hs_p & ~hs_r;
  assign vs_edge = vs_p & ~vs_r;

  // raster position; x is the index of the pixel currently on the bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      if (hs_edge)                        x <= '0;
      else if (PIX_EN && x != 16'hFFFF)   x <= x + 16'd1;
      if (vs_edge)                                      y <= '0;
      else if (hs_edge && x != '0 && y != 16'hFFFF)     y <= y + 16'd1;
    end
  end

  // window + decimation qualification
  always_comb begin
    dmask = ~(16'hFFFF << decim);
    x_off = x - win_x[15:0];
    y_off = y - win_y[15:0];
    qual  = PIX_EN &
            (x >= win_x[15:0]) & (x <= win_x[31:16]) &
            (y >= win_y[15:0]) & (y <= win_y[31:16]) &
            ((x_off & dmask) == '0) & ((y_off & dmask) == '0);
  end

  assign push_req = (state_q == S_CAPTURE) & qual & ~abort;
  assign push     = push_req & ~fifo_full;
  assign drop     = push_req & fifo_full;

  // FIFO pointers; abort flushes and overrides any same-cycle push or pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage (contents are don't-care once the pointers reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {VGA_R, VGA_G, VGA_B};
  end

  // capture FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // capture FSM next state; set_done marks the end of a captured frame
  always_comb begin
    state_d  = state_q;
    set_done = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (arm) state_d = S_WAIT_VS;
        S_WAIT_VS:      if (vs_edge) state_d = S_CAPTURE;
        S_CAPTURE: if (vs_edge) begin
          set_done = 1'b1;
          state_d  = cont ? S_CAPTURE : S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // host-writable configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      cont   <= 1'b0;
      win_x  <= 32'hFFFF_0000;
      win_y  <= 32'hFFFF_0000;
      decim  <= '0;
    end else if (chipselect && write) begin
      case (address)
        8'd0: begin irq_en <= writedata[1]; cont <= writedata[2]; end
        8'd2: win_x <= writedata;
        8'd3: win_y <= writedata;
        8'd4: decim <= writedata[1:0];
        default: ;
      endcase
    end
  end

  // sticky status flags and completed-capture counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (set_done)                      done <= 1'b1;
      else if (wr_stat && writedata[1])  done <= 1'b0;
      if (abort)                         overflow <= 1'b0;
      else if (drop)                     overflow <= 1'b1;
      else if (wr_stat && writedata[2])  overflow <= 1'b0;
      if (set_done) frame_cnt <= frame_cnt + 32'd1;
    end
  end

  // zero-latency read mux; idle bus reads as 0
  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        8'd0: readdata = {28'd0, 1'b0, cont, irq_en, 1'b0};
        8'd1: readdata = {16'(level), 11'd0, fifo_full, fifo_empty, overflow, done, busy};
        8'd2: readdata = win_x;
        8'd3: readdata = win_y;
        8'd4: readdata = {30'd0, decim};
        8'd5: if (!fifo_empty) readdata = {mem[rd_ptr[AW-1:0]], {PAD{1'b0}}};
        8'd6: readdata = frame_cnt;
        default: readdata = '0;
      endcase
    end
  end

endmodule
